// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states and
// instruction field positions.
package reg_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned DR_MSB  = 11;
  localparam int unsigned DR_LSB  = 9;
  localparam int unsigned SA_MSB  = 8;
  localparam int unsigned SA_LSB  = 6;
  localparam int unsigned SB_MSB  = 5;
  localparam int unsigned SB_LSB  = 3;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  // Ops that produce a register-file write (everything legal except NOP).
  function automatic logic is_write_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational ALU for the sequencer: result, carry/borrow/shift-out and
// opcode legality.
module alu8
  import reg_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             legal
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra MSB of the widened difference is the unsigned borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    legal  = 1'b1;
    case (op)
      OP_NOP: ;
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = a;
      OP_LDI: result = imm;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_file_sequencer.sv
// Four-state instruction sequencer driving the read selects and write port of
// an 8x8 register file: IDLE -> READ -> EXEC -> WRITE.
module reg_file_sequencer
  import reg_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0]       INSTR,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  input  logic [WIDTH-1:0]  DATA_A,
  input  logic [WIDTH-1:0]  DATA_B,
  output logic [ADDR_W-1:0] SA,
  output logic [ADDR_W-1:0] SB,
  output logic [ADDR_W-1:0] DR,
  output logic              LD,
  output logic [WIDTH-1:0]  D_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              ZERO,
  output logic              CARRY
);

  state_e           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] imm_q;
  logic             legal_q;
  logic             wr_q;
  logic             carry_res_q;

  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_legal;

  alu8 #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op     (op_q),
    .a      (DATA_A),
    .b      (DATA_B),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry),
    .legal  (alu_legal)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      imm_q       <= '0;
      legal_q     <= 1'b0;
      wr_q        <= 1'b0;
      carry_res_q <= 1'b0;
      SA          <= '0;
      SB          <= '0;
      DR          <= '0;
      D_OUT       <= '0;
      ZERO        <= 1'b0;
      CARRY       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (INSTR_VALID) begin
            op_q    <= INSTR[OP_MSB:OP_LSB];
            imm_q   <= WIDTH'(INSTR[IMM_MSB:IMM_LSB]);
            SA      <= ADDR_W'(INSTR[SA_MSB:SA_LSB]);
            SB      <= ADDR_W'(INSTR[SB_MSB:SB_LSB]);
            DR      <= ADDR_W'(INSTR[DR_MSB:DR_LSB]);
            state_q <= S_READ;
          end
        end
        S_READ: state_q <= S_EXEC;
        S_EXEC: begin
          legal_q     <= alu_legal;
          wr_q        <= is_write_op(op_q);
          carry_res_q <= alu_carry;
          // D_OUT keeps its previous value for NOP and illegal ops.
          if (is_write_op(op_q)) begin
            D_OUT <= alu_result;
          end
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_q) begin
            ZERO  <= (D_OUT == '0);
            CARRY <= carry_res_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Decoded straight from state so an async reset drops LD/DONE/ERR at once.
  assign INSTR_READY = (state_q == S_IDLE);
  assign BUSY        = (state_q != S_IDLE);
  assign DONE        = (state_q == S_WRITE);
  assign LD          = (state_q == S_WRITE) && wr_q;
  assign ERR         = (state_q == S_WRITE) && !legal_q;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Directed, table-driven bench for reg_file_sequencer with a behavioural 8x8
// register file attached to its select/load interface.
module tb_reg_file_sequencer;

  logic        CLK;
  logic        RST;
  logic [15:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [7:0]  DATA_A;
  logic [7:0]  DATA_B;
  logic [2:0]  SA;
  logic [2:0]  SB;
  logic [2:0]  DR;
  logic        LD;
  logic [7:0]  D_OUT;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic        ZERO;
  logic        CARRY;

  logic [7:0]  rf [8];
  logic        pre_we;
  logic [2:0]  pre_addr;
  logic [7:0]  pre_data;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] instr;
    logic        ld;
    logic        err;
    logic [7:0]  dout;
    logic        zero;
    logic        carry;
  } vec_t;

  localparam int NUM_VECS = 15;
  vec_t vecs [NUM_VECS];

  reg_file_sequencer #(
    .WIDTH  (8),
    .ADDR_W (3)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .INSTR       (INSTR),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .DATA_A      (DATA_A),
    .DATA_B      (DATA_B),
    .SA          (SA),
    .SB          (SB),
    .DR          (DR),
    .LD          (LD),
    .D_OUT       (D_OUT),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERR         (ERR),
    .ZERO        (ZERO),
    .CARRY       (CARRY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign DATA_A = rf[SA];
  assign DATA_B = rf[SB];

  always @(posedge CLK) begin
    if (LD) rf[DR] <= D_OUT;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Called at a negedge with the sequencer idle; returns at the negedge of cycle 4.
  task automatic run_instr(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    check({t, " ready_c0"}, 32'(INSTR_READY), 32'd1);
    INSTR       = v.instr;
    INSTR_VALID = 1'b1;
    next_cycle();
    INSTR_VALID = 1'b0;
    INSTR       = 16'hFFFF;
    check({t, " busy_c1"}, 32'(BUSY), 32'd1);
    check({t, " ready_c1"}, 32'(INSTR_READY), 32'd0);
    check({t, " sa_c1"}, 32'(SA), 32'(v.instr[8:6]));
    check({t, " sb_c1"}, 32'(SB), 32'(v.instr[5:3]));
    check({t, " ld_c1"}, 32'(LD), 32'd0);
    next_cycle();
    check({t, " ld_c2"}, 32'(LD), 32'd0);
    check({t, " done_c2"}, 32'(DONE), 32'd0);
    next_cycle();
    check({t, " ld_c3"}, 32'(LD), 32'(v.ld));
    check({t, " done_c3"}, 32'(DONE), 32'd1);
    check({t, " err_c3"}, 32'(ERR), 32'(v.err));
    if (v.ld) begin
      check({t, " dr_c3"}, 32'(DR), 32'(v.instr[11:9]));
      check({t, " dout_c3"}, 32'(D_OUT), 32'(v.dout));
    end
    next_cycle();
    check({t, " ready_c4"}, 32'(INSTR_READY), 32'd1);
    check({t, " done_c4"}, 32'(DONE), 32'd0);
    check({t, " err_c4"}, 32'(ERR), 32'd0);
    check({t, " zero_c4"}, 32'(ZERO), 32'(v.zero));
    check({t, " carry_c4"}, 32'(CARRY), 32'(v.carry));
    if (v.ld) check({t, " rf_c4"}, 32'(rf[v.instr[11:9]]), 32'(v.dout));
  endtask

  initial begin
    int    accepts;
    int    accept_mask;
    logic [7:0] r4_before;
    logic [2:0] c3;
    logic [7:0] c8;
    vec_t  v_r4;

    checks      = 0;
    errors      = 0;
    RST         = 1'b1;
    INSTR       = 16'h0000;
    INSTR_VALID = 1'b0;
    pre_we      = 1'b0;
    pre_addr    = 3'd0;
    pre_data    = 8'h00;

    //            instr     ld    err   dout   zero  carry
    vecs[0]  = '{16'h1650, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};  // ADD R3=R1+R2
    vecs[1]  = '{16'hC650, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};  // illegal 0xC
    vecs[2]  = '{16'h0650, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};  // NOP
    vecs[3]  = '{16'h7AA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};  // LDI R5=A5
    vecs[4]  = '{16'h2D50, 1'b1, 1'b0, 8'hB4, 1'b0, 1'b1};  // SUB R6=R5-R2
    vecs[5]  = '{16'hAE40, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1};  // SHR R7=R1
    vecs[6]  = '{16'h3E50, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};  // AND R7=R1,R2
    vecs[7]  = '{16'h4050, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};  // OR  R0=R1,R2
    vecs[8]  = '{16'h5050, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};  // XOR R0=R1,R2
    vecs[9]  = '{16'h6940, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};  // MOV R4=R5
    vecs[10] = '{16'h8080, 1'b1, 1'b0, 8'h0E, 1'b0, 1'b0};  // NOT R0=~R2
    vecs[11] = '{16'h9080, 1'b1, 1'b0, 8'hE2, 1'b0, 1'b1};  // SHL R0=R2
    vecs[12] = '{16'h2048, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};  // SUB R0=R1-R1
    vecs[13] = '{16'h1048, 1'b1, 1'b0, 8'h1E, 1'b0, 1'b0};  // ADD R0=R1+R1
    vecs[14] = '{16'hF000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};  // illegal 0xF

    // Preload the register file while the sequencer is held in reset.
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      pre_we   = 1'b1;
      pre_addr = 3'(i);
      pre_data = (i == 1) ? 8'h0F : (i == 2) ? 8'hF1 : 8'h00;
    end
    @(negedge CLK);
    pre_we = 1'b0;
    RST    = 1'b0;
    @(negedge CLK);

    check("rst ready", 32'(INSTR_READY), 32'd1);
    check("rst busy", 32'(BUSY), 32'd0);
    check("rst ld", 32'(LD), 32'd0);
    check("rst done", 32'(DONE), 32'd0);
    check("rst err", 32'(ERR), 32'd0);
    check("rst sel", {20'd0, SA, SB, DR, 3'd0}, 32'd0);
    check("rst dout", 32'(D_OUT), 32'd0);
    check("rst flags", {30'd0, ZERO, CARRY}, 32'd0);

    for (int i = 0; i < NUM_VECS; i++) run_instr(vecs[i], i);

    // INSTR_VALID held for 10 cycles with a different LDI each cycle.
    accepts     = 0;
    accept_mask = 0;
    for (int c = 0; c < 10; c++) begin
      c3          = 3'(c);
      c8          = 8'(c * 8'h11);
      INSTR       = {4'h7, c3, 1'b0, c8};
      INSTR_VALID = 1'b1;
      if (INSTR_READY) begin
        accepts++;
        accept_mask |= (1 << c);
      end
      next_cycle();
    end
    INSTR_VALID = 1'b0;
    repeat (3) next_cycle();
    check("hold accepts", 32'(accepts), 32'd3);
    check("hold accept cycles", 32'(accept_mask), 32'h111);
    check("hold ready", 32'(INSTR_READY), 32'd1);
    check("hold rf0", 32'(rf[0]), 32'h88);
    check("hold rf4", 32'(rf[4]), 32'h44);
    check("hold rf1", 32'(rf[1]), 32'h0F);
    check("hold rf2", 32'(rf[2]), 32'hF1);

    // Reset during the WRITE cycle of ADD R4=R1+R2.
    r4_before   = rf[4];
    INSTR       = 16'h1850;
    INSTR_VALID = 1'b1;
    next_cycle();
    INSTR_VALID = 1'b0;
    next_cycle();
    next_cycle();
    check("mid ld_write", 32'(LD), 32'd1);
    RST = 1'b1;
    #1;
    check("mid ld_async", 32'(LD), 32'd0);
    check("mid done", 32'(DONE), 32'd0);
    check("mid err", 32'(ERR), 32'd0);
    check("mid ready", 32'(INSTR_READY), 32'd1);
    check("mid busy", 32'(BUSY), 32'd0);
    check("mid sel", {20'd0, SA, SB, DR, 3'd0}, 32'd0);
    check("mid dout", 32'(D_OUT), 32'd0);
    check("mid flags", {30'd0, ZERO, CARRY}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    check("mid rf4", 32'(rf[4]), 32'(r4_before));
    check("mid done_after", 32'(DONE), 32'd0);
    v_r4 = '{16'h1850, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    run_instr(v_r4, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sequencer.md
Name: reg_file_sequencer

Overview:
- Multi-cycle instruction sequencer that drives the write side and read selects of the 8x8 register file.
- Accepts one 16-bit instruction per handshake and drives SA/SB to read two operands.
- Computes an 8-bit result and issues a single-cycle LD write to DR.
- Sits between instruction fetch and the register file. It is the initiator/controller for the register file's select/load interface.

Parameters:
- WIDTH, 8, data width of register file operands and result.
- ADDR_W, 3, register select width (8 registers).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- INSTR  input  16  instruction word, sampled on handshake.
- INSTR_VALID  input  1  fetch side presents INSTR.
- INSTR_READY  output  1  sequencer can accept; high exactly when state is IDLE.
- DATA_A  input  WIDTH  register file read port A (combinational from SA).
- DATA_B  input  WIDTH  register file read port B (combinational from SB).
- SA  output  ADDR_W  read select A.
- SB  output  ADDR_W  read select B.
- DR  output  ADDR_W  write destination.
- LD  output  1  write enable to register file; one-cycle pulse.
- D_OUT  output  WIDTH  write data to register file (D_in).
- BUSY  output  1  high in any non-IDLE state.
- DONE  output  1  one-cycle pulse when an instruction retires.
- ERR  output  1  one-cycle pulse, coincident with DONE, for an illegal opcode.
- ZERO  output  1  registered flag: last written result == 0.
- CARRY  output  1  registered flag: carry, borrow or shift-out of the last write.

Behaviour:
- Instruction format:
  - OP = INSTR[15:12], DR field = [11:9], SA field = [8:6], SB field = [5:3], [2:0] ignored.
  - For LDI only: IMM = INSTR[7:0].
- Opcodes:
  - 0 NOP (no write).
  - 1 ADD A+B; CARRY = bit 8 of the sum.
  - 2 SUB A-B; CARRY = borrow (A<B unsigned).
  - 3 AND, 4 OR, 5 XOR; CARRY = 0.
  - 6 MOV: result A; CARRY = 0.
  - 7 LDI: result IMM; CARRY = 0.
  - 8 NOT: result ~A; CARRY = 0.
  - 9 SHL: A<<1; CARRY = A[7].
  - A SHR: A>>1 logical; CARRY = A[0].
  - B-F illegal: no write; ERR pulses.
- All arithmetic is modulo 2^WIDTH.
- FSM states: IDLE, READ, EXEC, WRITE. One instruction every 4 cycles.
  - IDLE: INSTR_READY=1. On INSTR_VALID=1 at the edge, latch INSTR and go to READ. Otherwise stay.
  - READ (cycle 1 after accept): SA/SB are driven from the latched fields. Settling cycle only; no capture. Go to EXEC.
  - EXEC (cycle 2): capture DATA_A/DATA_B, compute the result and next flags into registers. Go to WRITE.
  - WRITE (cycle 3): for ops 1-A, LD=1, DR=latched DR, D_OUT=result; ZERO/CARRY update at the end of this cycle. For NOP and illegal ops, LD=0 and flags are unchanged. DONE=1 always; ERR=1 for illegal ops. Go to IDLE.
- LD, DONE and ERR are decoded from the state and the latched op. They are high only in WRITE, never glitching across states.
- SA, SB, DR and D_OUT are registered. They hold their last values in IDLE.
- Back-to-back hazards: a write lands at the WRITE edge, and the next instruction's READ is at least 2 cycles later. Reading the just-written register therefore returns the new value; no bypass is needed.
- INSTR_VALID high while BUSY is ignored, and INSTR is not sampled.
- Reset values: state=IDLE, SA=SB=DR=0, D_OUT=0, LD=0, DONE=0, ERR=0, ZERO=0, CARRY=0, BUSY=0, INSTR_READY=1.
- RST asserted mid-instruction, including during WRITE:
  - State returns to IDLE immediately and LD deasserts asynchronously.
  - The in-flight instruction is discarded with no DONE.
  - Register file contents are not reset by this block.

Decomposition:
- Shared package reg_seq_pkg holds:
  - opcode constants OP_NOP..OP_SHR;
  - state encoding constants S_IDLE..S_WRITE;
  - instruction field bit positions.
- One combinational sub-module, alu8: inputs op, a, b, imm; outputs result, carry, legal. It is instantiated once in EXEC.
- The FSM and output registers stay in reg_file_sequencer.

Test Plan:
- Bench setup: instantiate with a behavioural 8x8 register file model, preloading R1=0x0F and R2=0xF1.
- ADD R3=R1+R2 -> LD high exactly 3 cycles after accept, DR=3, D_OUT=0x00, then ZERO=1, CARRY=1, DONE pulse.
- LDI R5=0xA5, then immediately SUB R6=R5-R2 -> second instruction reads 0xA5; D_OUT=0xB4, CARRY=1 (borrow), ZERO=0.
- SHR R7=R1 -> D_OUT=0x07, CARRY=1. Then AND R7=R1,R2 -> D_OUT=0x01, CARRY=0.
- Opcode 0xC and NOP -> no LD for either. Illegal op: DONE and ERR both pulse. NOP: DONE only, ERR=0. ZERO/CARRY unchanged, INSTR_READY back high at cycle 4.
- INSTR_VALID held high for 10 cycles with changing INSTR -> exactly 3 accepts, at cycles 0, 4 and 8; words presented while BUSY are ignored.
- RST pulsed during the WRITE cycle of ADD R4 -> LD drops within the cycle, R4 unchanged in the model, no DONE, all outputs at reset values, next instruction accepted normally.
